// File: rtl/mdu_pkg.sv
// Shared types and constants for the M-extension divider.
package mdu_pkg;

  // Divide-class operation, encoded as the low two funct3 bits of the instruction.
  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COMPUTE = 2'b01,
    DONE    = 2'b10
  } div_state_t;

  // Most negative 32-bit value; DIV_INT_MIN / -1 is the signed overflow case.
  localparam logic [31:0] DIV_INT_MIN = 32'h8000_0000;

endpackage : mdu_pkg

// File: rtl/mdu_divider_divu_core.sv
// Unsigned restoring shift-subtract datapath: one quotient bit per step, MSB first.
// The dividend is shifted out of the quotient register as quotient bits shift in.
module divu_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_nxt,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt_q;

  // The shifted partial remainder is one bit wider than the operands, so the
  // trial subtract always sees the full value and never truncates.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_diff;
  logic             ge;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dvs_q};
    ge        = (rem_shift >= {1'b0, dvs_q});
    rem_d     = ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_d     = {quo_q[WIDTH-2:0], ge};
  end

  assign quo_nxt = quo_d;
  assign rem_nxt = rem_d;
  assign last    = (cnt_q == '0);

  // Operand load, per-step update and counter; abort clears the counter.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
      cnt_q <= CW'(WIDTH - 1);
    end else if (step) begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule : divu_core

// File: rtl/mdu_divider.sv
// Iterative DIV/DIVU/REM/REMU unit for EX: FSM, sign handling, special cases, stall.
module mdu_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  div_state_t       state_q;
  logic             is_rem_q;
  logic             neg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;

  div_op_t          op_in;
  logic             signed_op;
  logic             is_rem_op;
  logic             div_zero;
  logic             overflow;
  logic             special;
  logic             accept;
  logic             neg_in;
  logic [WIDTH-1:0] abs_dividend;
  logic [WIDTH-1:0] abs_divisor;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH-1:0] raw_res;
  logic [WIDTH-1:0] final_res;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic             core_load;
  logic             core_step;
  logic             core_last;

  // Decode the incoming request: special cases, magnitudes and result sign.
  always_comb begin
    op_in        = div_op_t'(op);
    signed_op    = (op_in == DIV) || (op_in == REM);
    is_rem_op    = (op_in == REM) || (op_in == REMU);
    div_zero     = (divisor == '0);
    overflow     = signed_op && (dividend == INT_MIN) && (divisor == ALL_ONES);
    special      = div_zero || overflow;
    accept       = (state_q == IDLE) && start && !flush;
    abs_dividend = (signed_op && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
    abs_divisor  = (signed_op && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
    // Remainder takes the dividend's sign; quotient the XOR of both signs.
    neg_in       = signed_op && (is_rem_op ? dividend[WIDTH-1]
                                           : (dividend[WIDTH-1] ^ divisor[WIDTH-1]));
    if (div_zero) begin
      special_res = is_rem_op ? dividend : ALL_ONES;
    end else begin
      special_res = is_rem_op ? '0 : dividend;
    end
    raw_res      = is_rem_q ? rem_nxt : quo_nxt;
    final_res    = neg_q ? (~raw_res + 1'b1) : raw_res;
    core_load    = accept && !special;
    core_step    = (state_q == COMPUTE) && !flush;
  end

  divu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush),
    .load     (core_load),
    .step     (core_step),
    .dividend (abs_dividend),
    .divisor  (abs_divisor),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt),
    .last     (core_last)
  );

  // Control FSM with registered busy/done/result; reset beats flush beats start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      is_rem_q <= 1'b0;
      neg_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            is_rem_q <= is_rem_op;
            neg_q    <= neg_in;
            if (special) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (core_last) begin
            result_q <= final_res;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall  = accept || (state_q == COMPUTE);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule : mdu_divider
